// File: rtl/m_ifetch.sv
// m_ifetch: instruction fetch with a 2-deep {pc, ir} queue, one in-flight memory read and a RUN/HALT FSM.
// Define IFETCH_PERF_EN to build the transfer/redirect performance counters.
module m_ifetch (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_redirect,
    input  logic [31:0] w_tpc,
    output logic [10:0] w_imem_addr,
    input  logic [31:0] w_imem_rdata,
    input  logic        w_dec_ready,
    output logic        r_dec_valid,
    output logic [31:0] r_dec_ir,
    output logic [31:0] r_dec_pc,
    output logic        r_halted,
    output logic [31:0] r_fetch_cnt,
    output logic [31:0] r_flush_cnt
);
    localparam logic [31:0] HALT_IR = 32'h1000ffff;
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nx;
    logic [31:0] r_pc, fl_pc;
    logic        fl_v;
    logic [31:0] q_pc [2];
    logic [31:0] q_ir [2];
    logic [1:0]  q_cnt, pend;
    logic [10:0] addr_q;
    logic        pop, push, issue, slot;
    always_comb begin
        pop      = r_dec_valid && w_dec_ready;
        push     = fl_v && state == RUN;
        pend     = q_cnt + {1'b0, fl_v} - {1'b0, pop};
        issue    = state == RUN && !w_redirect && pend < 2'd2;
        slot     = q_cnt[0] ^ pop;
        state_nx = w_redirect ? RUN : (pop && q_ir[0] == HALT_IR) ? HALT : state;
    end
    assign r_dec_valid = q_cnt != 2'd0 && state == RUN;
    assign r_dec_ir    = q_ir[0];
    assign r_dec_pc    = q_pc[0];
    assign r_halted    = state == HALT;
    assign w_imem_addr = issue ? r_pc[12:2] : addr_q;
    always_ff @(posedge w_clk)
        state <= w_rst ? RUN : state_nx;
    // Redirect outranks pop/push; in HALT the issue and push paths are both idle.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_pc    <= '0;
            fl_pc   <= '0;
            fl_v    <= 1'b0;
            q_cnt   <= '0;
            addr_q  <= '0;
            q_pc[0] <= '0;
            q_pc[1] <= '0;
            q_ir[0] <= '0;
            q_ir[1] <= '0;
        end else if (w_redirect) begin
            r_pc  <= w_tpc & ~32'd3;
            fl_v  <= 1'b0;
            q_cnt <= '0;
        end else begin
            fl_v <= issue;
            if (issue) begin
                fl_pc  <= r_pc;
                r_pc   <= r_pc + 32'd4;
                addr_q <= r_pc[12:2];
            end
            if (pop) begin
                q_pc[0] <= q_pc[1];
                q_ir[0] <= q_ir[1];
            end
            if (push) begin
                q_pc[slot] <= fl_pc;
                q_ir[slot] <= w_imem_rdata;
            end
            q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
        end
    end
`ifdef IFETCH_PERF_EN
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_redirect) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end
`else
    assign r_fetch_cnt = '0;
    assign r_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_m_ifetch.sv
// tb_m_ifetch: directed bench for m_ifetch with a 1-cycle synchronous instruction memory.
module tb_m_ifetch;
    logic        w_clk = 1'b0, w_rst = 1'b1, w_redirect = 1'b0, w_dec_ready = 1'b0;
    logic [31:0] w_tpc = '0, w_imem_rdata;
    logic [10:0] w_imem_addr;
    logic        r_dec_valid, r_halted;
    logic [31:0] r_dec_ir, r_dec_pc, r_fetch_cnt, r_flush_cnt;
    logic [31:0] mem [2048];
    int          total = 0, bad = 0;
    logic        ev, eh;
    logic [31:0] ep, ei;
    logic [10:0] ea;

    m_ifetch dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_redirect(w_redirect), .w_tpc(w_tpc),
        .w_imem_addr(w_imem_addr), .w_imem_rdata(w_imem_rdata), .w_dec_ready(w_dec_ready),
        .r_dec_valid(r_dec_valid), .r_dec_ir(r_dec_ir), .r_dec_pc(r_dec_pc),
        .r_halted(r_halted), .r_fetch_cnt(r_fetch_cnt), .r_flush_cnt(r_flush_cnt)
    );

    always #5 w_clk = ~w_clk;
    always @(posedge w_clk) w_imem_rdata <= mem[w_imem_addr];

    // Enter the next cycle, apply its inputs, and let combinational outputs settle.
    task automatic go(input logic rst, input logic rd, input logic [31:0] tpc, input logic rdy);
        @(posedge w_clk);
        #1;
        w_rst = rst;
        w_redirect = rd;
        w_tpc = tpc;
        w_dec_ready = rdy;
        #1;
    endtask

    task automatic test_reset;
        go(1, 0, 0, 0);
        go(0, 0, 0, 0);
        total++;
        if ({r_dec_valid, r_dec_ir, r_dec_pc, r_halted, r_fetch_cnt, r_flush_cnt} !== 130'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b ir=%h pc=%h h=%b fc=%0d rc=%0d want all zero",
                     r_dec_valid, r_dec_ir, r_dec_pc, r_halted, r_fetch_cnt, r_flush_cnt);
        end
        total++;
        if (w_imem_addr !== 11'd0) begin
            bad++;
            $display("FAIL reset_addr got %h want 000", w_imem_addr);
        end
    endtask

    task automatic test_stream;
        go(1, 0, 0, 1);
        for (int c = 1; c <= 10; c++) begin
            go(0, 0, 0, 1);
            ev = c >= 3; eh = 0; ea = 11'(c - 1);
            ep = 32'(4 * (c - 3)); ei = 32'hA0000000 + 32'(c - 3);
            total++;
            if (ev ? {r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr} !== {ev, eh, ep, ei, ea}
                   : {r_dec_valid, r_halted, w_imem_addr} !== {1'b0, eh, ea}) begin
                bad++;
                $display("FAIL stream c=%0d got v=%b h=%b pc=%h ir=%h a=%h want v=%b h=%b pc=%h ir=%h a=%h",
                         c, r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr, ev, eh, ep, ei, ea);
            end
        end
    endtask

    task automatic test_stall;
        go(1, 0, 0, 1);
        for (int c = 1; c <= 10; c++) begin
            go(0, 0, 0, !(c >= 3 && c <= 6));
            ev = c >= 3; eh = 0;
            ea = c <= 2 ? 11'(c - 1) : c <= 6 ? 11'd1 : 11'(c - 5);
            ep = c <= 7 ? 32'd0 : 32'(4 * (c - 7));
            ei = 32'hA0000000 + (ep >> 2);
            total++;
            if (ev ? {r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr} !== {ev, eh, ep, ei, ea}
                   : {r_dec_valid, r_halted, w_imem_addr} !== {1'b0, eh, ea}) begin
                bad++;
                $display("FAIL stall c=%0d got v=%b h=%b pc=%h ir=%h a=%h want v=%b h=%b pc=%h ir=%h a=%h",
                         c, r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr, ev, eh, ep, ei, ea);
            end
        end
    endtask

    task automatic test_redirect;
        go(1, 0, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            go(0, c == 4, 32'h00000043, c != 3);
            eh = 0;
            ev = c == 3 || c == 4 || c >= 7;
            ea = c <= 2 ? 11'(c - 1) : c <= 4 ? 11'd1 : 11'(c + 11);
            ep = c <= 4 ? 32'd0 : 32'h40 + 32'(4 * (c - 7));
            ei = 32'hA0000000 + (ep >> 2);
            total++;
            if (ev ? {r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr} !== {ev, eh, ep, ei, ea}
                   : {r_dec_valid, r_halted, w_imem_addr} !== {1'b0, eh, ea}) begin
                bad++;
                $display("FAIL redirect c=%0d got v=%b h=%b pc=%h ir=%h a=%h want v=%b h=%b pc=%h ir=%h a=%h",
                         c, r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr, ev, eh, ep, ei, ea);
            end
        end
    endtask

    task automatic test_halt;
        mem[4] = 32'h1000ffff;
        go(1, 0, 0, 1);
        for (int c = 1; c <= 13; c++) begin
            go(0, c == 10, 32'h0, 1);
            eh = c >= 8 && c <= 10;
            ev = (c >= 3 && c <= 7) || c == 13;
            ea = c <= 7 ? 11'(c - 1) : c <= 10 ? 11'd6 : 11'(c - 11);
            ep = c == 13 ? 32'd0 : 32'(4 * (c - 3));
            ei = c == 7 ? 32'h1000ffff : 32'hA0000000 + (ep >> 2);
            total++;
            if (ev ? {r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr} !== {ev, eh, ep, ei, ea}
                   : {r_dec_valid, r_halted, w_imem_addr} !== {1'b0, eh, ea}) begin
                bad++;
                $display("FAIL halt c=%0d got v=%b h=%b pc=%h ir=%h a=%h want v=%b h=%b pc=%h ir=%h a=%h",
                         c, r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr, ev, eh, ep, ei, ea);
            end
        end
        mem[4] = 32'hA0000004;
    endtask

    task automatic test_wrap;
        go(1, 0, 0, 1);
        for (int c = 1; c <= 15; c++) begin
            go(0, c == 1 || c == 14, c == 1 ? 32'hFFFFFFFC : 32'h0, c != 14);
            eh = 0;
            ev = c >= 4 && c <= 14;
            ea = c == 1 ? 11'd0 : c == 2 ? 11'h7FF : c == 15 ? 11'd0 : c == 14 ? 11'd10 : 11'(c - 3);
            ep = c == 4 ? 32'hFFFFFFFC : 32'(4 * (c - 5));
            ei = c == 4 ? 32'hA00007FF : 32'hA0000000 + 32'(c - 5);
            total++;
            if (ev ? {r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr} !== {ev, eh, ep, ei, ea}
                   : {r_dec_valid, r_halted, w_imem_addr} !== {1'b0, eh, ea}) begin
                bad++;
                $display("FAIL wrap c=%0d got v=%b h=%b pc=%h ir=%h a=%h want v=%b h=%b pc=%h ir=%h a=%h",
                         c, r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr, ev, eh, ep, ei, ea);
            end
        end
`ifdef IFETCH_PERF_EN
        ep = 32'd10; ei = 32'd2;
`else
        ep = 32'd0; ei = 32'd0;
`endif
        total++;
        if ({r_fetch_cnt, r_flush_cnt} !== {ep, ei}) begin
            bad++;
            $display("FAIL perf_cnt got fetch=%0d flush=%0d want fetch=%0d flush=%0d",
                     r_fetch_cnt, r_flush_cnt, ep, ei);
        end
    endtask

    task automatic test_reset_mid;
        go(1, 0, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            go(c == 5, c == 5, 32'h80, 1);
            eh = 0;
            ev = (c >= 3 && c <= 5) || c == 8;
            ea = c <= 4 ? 11'(c - 1) : c == 5 ? 11'd3 : 11'(c - 6);
            ep = c == 8 ? 32'd0 : 32'(4 * (c - 3));
            ei = 32'hA0000000 + (ep >> 2);
            total++;
            if (ev ? {r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr} !== {ev, eh, ep, ei, ea}
                   : {r_dec_valid, r_halted, w_imem_addr} !== {1'b0, eh, ea}) begin
                bad++;
                $display("FAIL reset_mid c=%0d got v=%b h=%b pc=%h ir=%h a=%h want v=%b h=%b pc=%h ir=%h a=%h",
                         c, r_dec_valid, r_halted, r_dec_pc, r_dec_ir, w_imem_addr, ev, eh, ep, ei, ea);
            end
            if (c == 6) begin
                total++;
                if ({r_dec_ir, r_dec_pc, r_fetch_cnt, r_flush_cnt} !== 128'd0) begin
                    bad++;
                    $display("FAIL reset_mid_state got ir=%h pc=%h fc=%0d rc=%0d want all zero",
                             r_dec_ir, r_dec_pc, r_fetch_cnt, r_flush_cnt);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA0000000 + 32'(i);
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_halt;
        test_wrap;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_ifetch.md
M_IFETCH -- requirements
Module: m_ifetch

Interface
REQ-001 The port w_clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-002 The port w_rst SHALL be an input, 1 bit wide, and act as a synchronous, active-high reset.
REQ-003 The port w_redirect SHALL be an input, 1 bit wide, and indicate that decode requests a taken-branch redirect this cycle.
REQ-004 The port w_tpc SHALL be an input, 32 bits wide, and carry the redirect target PC.
REQ-005 The port w_imem_addr SHALL be an output, 11 bits wide, and carry the instruction-memory word address (byte PC bits [12:2]).
REQ-006 The port w_imem_rdata SHALL be an input, 32 bits wide, and carry the instruction word; it SHALL be valid exactly 1 cycle after its address is issued.
REQ-007 The port w_dec_ready SHALL be an input, 1 bit wide, and indicate that the decode stage accepts the current word.
REQ-008 The port r_dec_valid SHALL be an output, 1 bit wide, and indicate that r_dec_ir and r_dec_pc hold a valid instruction.
REQ-009 The port r_dec_ir SHALL be an output, 32 bits wide, and carry the instruction word to decode.
REQ-010 The port r_dec_pc SHALL be an output, 32 bits wide, and carry the byte PC of r_dec_ir.
REQ-011 The port r_halted SHALL be an output, 1 bit wide, and be high while the block is in the HALT state.
REQ-012 The ports r_fetch_cnt and r_flush_cnt SHALL be outputs, 32 bits each, and carry the performance counters defined under Configuration.

Function
REQ-013 The block SHALL contain a fetch PC (r_pc), a 2-entry FIFO queue of {pc, ir} pairs, one in-flight tag (valid + pc), and a 2-state FSM with states RUN and HALT.
REQ-014 The outputs r_dec_valid, r_dec_ir and r_dec_pc SHALL present the queue head; r_dec_valid SHALL equal "queue not empty and state RUN".
REQ-015 A transfer SHALL occur in a cycle where r_dec_valid and w_dec_ready are both high; the head is then popped at that cycle's edge.
REQ-016 In RUN without redirect, a fetch SHALL issue when (occupancy + in-flight - pop) < 2; an issue drives w_imem_addr=r_pc[12:2], sets the in-flight tag, and increments r_pc by 4.
REQ-017 Returning data SHALL be pushed into the queue with its tag pc at the edge following the issue cycle.
REQ-018 With w_dec_ready held high, steady-state throughput SHALL be 1 instruction per cycle.
REQ-019 First-valid latency SHALL be: reset released before cycle 1; issue pc 0 in cycle 1; r_dec_valid high in cycle 3.
REQ-020 When w_redirect is high, the block SHALL, at that edge, flush the queue, discard the in-flight return, set r_pc={w_tpc[31:2],2'b00}, and suppress issue that cycle.
REQ-021 A redirect SHALL take priority over a same-cycle pop or push; r_dec_valid SHALL be low in cycles N+1 and N+2 after a redirect in cycle N, and the target SHALL be valid in cycle N+3.
REQ-022 w_tpc[1:0] SHALL be ignored.
REQ-023 r_pc SHALL wrap modulo 2^32, and w_imem_addr SHALL wrap modulo 2048 words.
REQ-024 When the head equals 32'h1000ffff (HALT) and is transferred, the FSM SHALL go RUN->HALT.
REQ-025 In HALT, issue SHALL stop, r_dec_valid SHALL be 0, and any in-flight return SHALL be discarded.
REQ-026 The FSM SHALL go HALT->RUN only on w_redirect (handled as in REQ-020).
REQ-027 w_imem_addr SHALL be don't-care when no fetch issues; it SHALL hold its last value.

Reset
REQ-028 On w_rst=1 at an edge, the block SHALL set r_pc=0, empty the queue, clear the in-flight tag, set state RUN, r_dec_valid=0, r_dec_ir=0, r_dec_pc=0, r_halted=0, and both counters to 0.
REQ-029 A reset SHALL override a same-cycle redirect, transfer or push; a return for a pre-reset fetch SHALL be discarded.
REQ-030 w_rst asserted mid-stream SHALL restart fetch at pc 0 exactly as in REQ-019.

Configuration
REQ-031 With IFETCH_PERF_EN defined, r_fetch_cnt SHALL increment on every transfer and r_flush_cnt SHALL increment on every redirect cycle (wrapping modulo 2^32).
REQ-032 Without IFETCH_PERF_EN, both counter ports SHALL exist and be driven constant 0, and no counter registers SHALL be synthesized.

Verification
REQ-033 Reset then w_dec_ready=1, with memory words 0..7 = 32'hA0000000+i -> r_dec_valid first high in cycle 3 with pc 0/ir A0000000, then pc 4, 8, ... on consecutive cycles, no gaps.
REQ-034 w_dec_ready=0 for cycles 3-6, then 1 -> at most 2 fetches are outstanding, w_imem_addr holds, and output resumes pc 0, 4, 8 in order with no loss or duplication.
REQ-035 w_redirect=1 with w_tpc=32'h00000043 while the queue is full -> valid is low 2 cycles, then pc 32'h40 is delivered, and no pre-redirect word appears.
REQ-036 Word 32'h1000ffff at pc 0x10 is transferred -> r_halted=1 next cycle, r_dec_valid stays 0; a later redirect to 0x0 -> pc 0 is valid 3 cycles later with r_halted=0.
REQ-037 r_pc=32'hFFFFFFFC is reached via redirect -> the next fetch is pc 0 with w_imem_addr 0; with IFETCH_PERF_EN, after 10 transfers and 2 redirects the counters read 10 and 2 (and 0/0 without the macro).
REQ-038 w_rst is pulsed in the same cycle as w_redirect and a transfer -> the post-reset state matches REQ-028, and the next delivered pc is 0.
